// File: rtl/vr_pkg.sv
// vr_pkg - shared definitions for the virtual-channel credit transmitter.
//
// Contents:
//   NUM_VC_DEFAULT    default number of virtual channels on the link
//   BUF_DEPTH_DEFAULT default downstream fifo depth per VC (initial credits)
//   VC_ID_WIDTH       width of a VC identifier
//   FLIT_DATA_WIDTH   flit payload width shared by the link
//   CREDIT_WIDTH      width of one credit counter (0..BUF_DEPTH_DEFAULT)
//   credit_t          credit-count type
//
// Optional feature macro used by this slice: VC_CREDIT_CHECK_EN.

package vr_pkg;

   localparam int NUM_VC_DEFAULT    = 4;
   localparam int BUF_DEPTH_DEFAULT = 8;
   localparam int VC_ID_WIDTH       = $clog2(NUM_VC_DEFAULT);

   localparam int FLIT_DATA_WIDTH   = 32;

   localparam int CREDIT_WIDTH      = $clog2(BUF_DEPTH_DEFAULT + 1);

   typedef logic [CREDIT_WIDTH-1:0] credit_t;

endpackage

// File: rtl/vc_credit_counter.sv
// vc_credit_counter - one per-VC credit counter.
//
// Ports:
//   clk       clock, state updates on posedge
//   reset     asynchronous active-low reset, loads BUF_DEPTH
//   inc       credit returned for this VC
//   dec       flit transferred on this VC
//   count     registered credit count
//   nonzero   count != 0
//   overflow  a return arrived while already full (saturating build only)
//
// Macro VC_CREDIT_CHECK_EN: when defined the counter saturates at BUF_DEPTH
// and reports overflow; otherwise an extra return simply wraps and
// overflow is tied low.

module vc_credit_counter #(
  parameter int BUF_DEPTH = 8,
  parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  // Simultaneous inc and dec cancel, so only the one-sided cases move the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= FULL;
    end else if (inc && !dec) begin
`ifdef VC_CREDIT_CHECK_EN
      if (count != FULL) begin
        count <= count + ONE;
      end
`else
      count <= count + ONE;
`endif
    end else if (dec && !inc) begin
      count <= count - ONE;
    end
  end

  assign nonzero = (count != '0);

`ifdef VC_CREDIT_CHECK_EN
  assign overflow = inc && !dec && (count == FULL);
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: rtl/vc_credit_tx.sv
// vc_credit_tx - credit-based flit transmitter for a multi-VC link.
//
// Ports:
//   clk           clock, state updates on posedge
//   reset         asynchronous active-low reset
//   in_valid      switch offers a flit
//   in_vc         target VC of the offered flit
//   in_data       offered flit payload
//   in_ready      flit accepted this cycle (credit available on in_vc)
//   out_valid     registered flit valid to the downstream fifo push
//   out_vc        registered VC id
//   out_data      registered payload
//   credit_valid  downstream popped one flit
//   credit_vc     VC of the returned credit
//   credit_avail  bit v high when VC v has credit
//   credit_err    sticky credit-overflow flag
//
// Macro VC_CREDIT_CHECK_EN: enables counter saturation and the sticky
// credit_err flag; without it credit_err is constant 0.

module vc_credit_tx
  import vr_pkg::*;
#(
  parameter int NUM_VC    = NUM_VC_DEFAULT,
  parameter int BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [VC_ID_WIDTH-1:0]     in_vc,
  input  logic [FLIT_DATA_WIDTH-1:0] in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [VC_ID_WIDTH-1:0]     out_vc,
  output logic [FLIT_DATA_WIDTH-1:0] out_data,
  input  logic                       credit_valid,
  input  logic [VC_ID_WIDTH-1:0]     credit_vc,
  output logic [NUM_VC-1:0]          credit_avail,
  output logic                       credit_err
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [CNT_W-1:0]  counts [NUM_VC];
  logic [NUM_VC-1:0] ovf;
  logic              in_vc_ok;
  logic              credit_vc_ok;
  logic              transfer;

  // Out-of-range VC ids never match a counter, so they are silently dropped.
  assign in_vc_ok     = (int'(in_vc) < NUM_VC);
  assign credit_vc_ok = (int'(credit_vc) < NUM_VC);

  assign in_ready = in_vc_ok && (counts[in_vc] != '0);
  assign transfer = in_valid && in_ready;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic inc_v;
    logic dec_v;

    assign dec_v = transfer && (in_vc == VC_ID_WIDTH'(v));
    assign inc_v = credit_valid && credit_vc_ok && (credit_vc == VC_ID_WIDTH'(v));

    vc_credit_counter #(
      .BUF_DEPTH (BUF_DEPTH),
      .CNT_W     (CNT_W)
    ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .inc      (inc_v),
      .dec      (dec_v),
      .count    (counts[v]),
      .nonzero  (credit_avail[v]),
      .overflow (ovf[v])
    );
  end

  // Output stage: one-cycle registered copy of each accepted flit; the
  // payload holds its last value between transfers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_vc    <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= transfer;
      if (transfer) begin
        out_vc   <= in_vc;
        out_data <= in_data;
      end
    end
  end

`ifdef VC_CREDIT_CHECK_EN
  // Once any counter overflows the flag stays up until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit_err <= 1'b0;
    end else if (|ovf) begin
      credit_err <= 1'b1;
    end
  end
`else
  // Counters tie overflow low in this build, so this is constant 0.
  assign credit_err = |ovf;
`endif

endmodule

// File: doc/vc_credit_tx.md
VC_CREDIT_TX -- requirements
Module: vc_credit_tx

Interface
REQ-001 SHALL have parameter NUM_VC, default 4: number of virtual channels on the link.
REQ-002 SHALL have parameter BUF_DEPTH, default 8: downstream fifo depth per VC, which is the initial credit count.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1: switch offers a flit.
REQ-006 SHALL have port in_vc  input  VC_ID_WIDTH: target VC of the offered flit.
REQ-007 SHALL have port in_data  input  FLIT_DATA_WIDTH: offered flit payload.
REQ-008 SHALL have port in_ready  output  1: flit is accepted this cycle.
REQ-009 SHALL have port out_valid  output  1: registered flit valid to the downstream fifo push.
REQ-010 SHALL have port out_vc  output  VC_ID_WIDTH: registered VC id to the downstream fifo.
REQ-011 SHALL have port out_data  output  FLIT_DATA_WIDTH: registered payload to the downstream fifo indata.
REQ-012 SHALL have port credit_valid  input  1: downstream popped one flit.
REQ-013 SHALL have port credit_vc  input  VC_ID_WIDTH: VC of the returned credit.
REQ-014 SHALL have port credit_avail  output  NUM_VC: bit v is high when credit[v] != 0.
REQ-015 SHALL have port credit_err  output  1: sticky credit-overflow flag (see Configuration).

Function
REQ-016 SHALL keep one credit counter per VC, width clog2(BUF_DEPTH+1), range 0..BUF_DEPTH.
REQ-017 SHALL drive in_ready combinationally as credit[in_vc] != 0; a flit transfers only when in_valid and in_ready are both high.
REQ-018 SHALL register each transferred flit to out_valid, out_vc and out_data with exactly 1-cycle latency; out_valid SHALL be low in any cycle following a non-transfer.
REQ-019 SHALL decrement credit[in_vc] by 1 on each transfer.
REQ-020 SHALL increment credit[credit_vc] by 1 on each credit_valid.
REQ-021 SHALL leave a counter unchanged when a transfer and a credit return hit the same VC in the same cycle, including at count 0, where in_ready is still low that cycle.
REQ-022 SHALL update both counters independently when a transfer and a credit return hit different VCs in the same cycle.
REQ-023 SHALL derive credit_avail from the registered counters, so it reflects updates one cycle after the event.
REQ-024 SHALL ignore in_vc values >= NUM_VC (in_ready low) and ignore credit_vc values >= NUM_VC.

Reset
REQ-025 SHALL, while reset is low, asynchronously set every counter to BUF_DEPTH, clear out_valid, out_vc, out_data and credit_err, and set credit_avail to all ones.
REQ-026 SHALL discard any flit in flight and any pending credit on reset assertion mid-operation; there is no replay.

Configuration
REQ-027 SHALL, with macro VC_CREDIT_CHECK_EN defined, saturate a counter at BUF_DEPTH when a credit return would exceed it, and set credit_err high until reset.
REQ-028 SHALL, without VC_CREDIT_CHECK_EN, omit the saturation and error logic and tie credit_err to 0; an overflowing return wraps modulo the counter width.

Structure
REQ-029 SHALL source FLIT_DATA_WIDTH from VR_define.vh.
REQ-030 SHALL place NUM_VC and BUF_DEPTH defaults, VC_ID_WIDTH = clog2(NUM_VC) and a credit-count typedef in shared package vr_pkg.
REQ-031 SHALL implement each counter as one instance of sub-module vc_credit_counter (inc, dec, count, nonzero, overflow), generated NUM_VC times.

Verification
REQ-032 Reset, then idle -> credit_avail=4'b1111, out_valid=0, credit_err=0, all counters at 8.
REQ-033 8 back-to-back flits on VC2 (data 0..7), no credits -> all 8 accepted, each appears on out_data 1 cycle later; 9th offer sees in_ready=0; credit_avail=4'b1011.
REQ-034 From VC2 at 0, one credit_valid on VC2 -> next cycle in_ready=1 for VC2; one flit accepted; counter back to 0.
REQ-035 VC1 at 3, simultaneous transfer and credit on VC1 -> VC1 stays at 3; out_valid=1 next cycle.
REQ-036 With VC_CREDIT_CHECK_EN, credit on VC0 at 8 -> VC0 stays 8, credit_err=1 until reset; without the macro, credit_err=0.
REQ-037 Reset asserted while VC3 at 5 and out_valid=1 -> out_valid=0 immediately, VC3 at 8 after release.
